// File: rtl/rename_unit_pkg.sv
// rename_unit_pkg: shared out-of-order pipeline types for the rename stage.
// Holds the register-file sizing, the fu_type enum, the decode->rename and
// rename->dispatch packet structs, and a helper for the effective rd write.
// No ports (package).
package rename_unit_pkg;

  localparam int NUM_ARCH  = 32;
  localparam int NUM_PHYS  = 64;
  localparam int AREG_W    = $clog2(NUM_ARCH);
  localparam int PREG_W    = $clog2(NUM_PHYS);
  localparam int FREE_INIT = NUM_PHYS - NUM_ARCH;

  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [PREG_W-1:0] preg_t;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_LSU = 2'd2,
    FU_BR  = 2'd3
  } fu_type_e;

  typedef struct packed {
    areg_t       rs1;
    areg_t       rs2;
    areg_t       rd;
    logic        rs1_used;
    logic        rs2_used;
    logic        rd_used;
    fu_type_e    fu_type;
    logic        is_branch;
    logic [31:0] payload;
  } decode_pkt_t;

  typedef struct packed {
    decode_pkt_t dec;
    preg_t       rs1_tag;
    preg_t       rs2_tag;
    preg_t       rd_new_tag;
    preg_t       rd_old_tag;
  } rename_pkt_t;

  // x0 is hard-wired, so a write to it never consumes a physical register.
  function automatic logic rd_writes(decode_pkt_t p);
    return p.rd_used && (p.rd != '0);
  endfunction

endpackage

// File: rtl/rename_unit_if.sv
// rename_unit_if: decode->rename and rename->dispatch valid/ready handshakes.
//   valid_in/pkt_in/ready_out : decoded instruction into rename
//   valid_out/pkt_out/ready_in: renamed packet out to dispatch
// Modports: master (decode/dispatch side), slave (rename_unit).
interface rename_unit_if;
  import rename_unit_pkg::*;

  logic        valid_in;
  logic        ready_out;
  decode_pkt_t pkt_in;
  logic        valid_out;
  logic        ready_in;
  rename_pkt_t pkt_out;

  modport master (
    output valid_in, pkt_in, ready_in,
    input  ready_out, valid_out, pkt_out
  );

  modport slave (
    input  valid_in, pkt_in, ready_in,
    output ready_out, valid_out, pkt_out
  );

endinterface

// File: rtl/rename_freelist.sv
// rename_freelist: circular FIFO of free physical tags, depth NUM_PHYS.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   pop         consume head_tag (rename of a dest-writer)
//   push        return push_tag to the tail (commit frees old tag)
//   push_tag    tag being freed
//   commit_pop  a dest-writer committed: advance the committed head
//   flush       rewind head to the committed head
//   head_tag    tag that the next pop will hand out
//   count       occupancy (tail - head), PREG_W+1 bits
module rename_freelist
  import rename_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            pop,
  input  logic            push,
  input  preg_t           push_tag,
  input  logic            commit_pop,
  input  logic            flush,
  output preg_t           head_tag,
  output logic [PREG_W:0] count
);

  typedef logic [PREG_W:0] ptr_t;

  preg_t slots [NUM_PHYS];
  ptr_t  head;
  ptr_t  tail;
  ptr_t  commit_head;

  // Pointers carry a wrap bit so the subtraction gives occupancy directly.
  assign head_tag = slots[head[PREG_W-1:0]];
  assign count    = tail - head;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYS; i++) begin
        slots[i] <= (i < FREE_INIT) ? preg_t'(NUM_ARCH + i) : '0;
      end
      head        <= '0;
      tail        <= ptr_t'(FREE_INIT);
      commit_head <= '0;
    end else begin
      if (push) begin
        slots[tail[PREG_W-1:0]] <= push_tag;
        tail                    <= tail + ptr_t'(1);
      end
      if (commit_pop) begin
        commit_head <= commit_head + ptr_t'(1);
      end
      // Entries between commit_head and head belong to squashed
      // instructions; rewinding head returns them to the pool in order.
      if (flush) begin
        head <= commit_pop ? commit_head + ptr_t'(1) : commit_head;
      end else if (pop) begin
        head <= head + ptr_t'(1);
      end
    end
  end

endmodule

// File: rtl/rename_unit.sv
// rename_unit: in-order, one-per-cycle register rename stage feeding dispatch.
// Reads the speculative map for source tags, pops a free tag for each
// destination, records the previous mapping, and registers the result.
// Commit frees old tags and updates the retirement map; flush restores it.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush_i             mispredict flush
//   bus (slave)         valid_in/ready_out/pkt_in, valid_out/ready_in/pkt_out
//   commit_*            ROB commit: rd_used, arch rd, new tag, old tag to free
//   free_count_o        free-list occupancy
// Optional (macro RENAME_PERF_CNT_EN):
//   stall_fl_cnt_o      saturating count of cycles stalled on empty free list
module rename_unit
  import rename_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  rename_unit_if.slave    bus,
  input  logic            commit_valid_i,
  input  logic            commit_rd_used_i,
  input  areg_t           commit_rd_arch_i,
  input  preg_t           commit_dest_new_i,
  input  preg_t           commit_dest_old_i,
  output logic [PREG_W:0] free_count_o
`ifdef RENAME_PERF_CNT_EN
  ,
  output logic [31:0]     stall_fl_cnt_o
`endif
);

  preg_t           map  [NUM_ARCH];
  preg_t           rrat [NUM_ARCH];
  logic            rd_used_eff;
  logic            ready;
  logic            fire;
  logic            pop;
  logic            commit_wr;
  preg_t           head_tag;
  logic [PREG_W:0] count;
  rename_pkt_t     pkt_p0;
  rename_pkt_t     pkt_p1;
  logic            vld_p1;

  rename_freelist u_freelist (
    .clk        (clk),
    .rst        (rst),
    .pop        (pop),
    .push       (commit_wr),
    .push_tag   (commit_dest_old_i),
    .commit_pop (commit_wr),
    .flush      (flush_i),
    .head_tag   (head_tag),
    .count      (count)
  );

  assign rd_used_eff = rd_writes(bus.pkt_in);
  assign ready       = (!vld_p1 || bus.ready_in) && (!rd_used_eff || count != '0) && !flush_i;
  assign fire        = bus.valid_in && ready;
  assign pop         = fire && rd_used_eff;
  assign commit_wr   = commit_valid_i && commit_rd_used_i;

  assign bus.ready_out = ready;
  assign bus.valid_out = vld_p1;
  assign bus.pkt_out   = pkt_p1;
  assign free_count_o  = count;

  // Stage p0: map lookup uses the pre-update table, so rs == rd sees the old tag.
  always_comb begin
    pkt_p0             = '0;
    pkt_p0.dec         = bus.pkt_in;
    pkt_p0.dec.rd_used = rd_used_eff;
    pkt_p0.rs1_tag     = map[bus.pkt_in.rs1];
    pkt_p0.rs2_tag     = map[bus.pkt_in.rs2];
    if (rd_used_eff) begin
      pkt_p0.rd_old_tag = map[bus.pkt_in.rd];
      pkt_p0.rd_new_tag = head_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        map[i]  <= preg_t'(i);
        rrat[i] <= preg_t'(i);
      end
    end else begin
      if (commit_wr) begin
        rrat[commit_rd_arch_i] <= commit_dest_new_i;
      end
      // Restore from the retirement map, forwarding a same-cycle commit.
      if (flush_i) begin
        for (int i = 0; i < NUM_ARCH; i++) begin
          map[i] <= (commit_wr && commit_rd_arch_i == areg_t'(i)) ? commit_dest_new_i : rrat[i];
        end
      end else if (pop) begin
        map[bus.pkt_in.rd] <= head_tag;
      end
    end
  end

  // Stage p1: output register toward dispatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      pkt_p1 <= '0;
    end else if (flush_i) begin
      vld_p1 <= 1'b0;
    end else if (fire) begin
      vld_p1 <= 1'b1;
      pkt_p1 <= pkt_p0;
    end else if (bus.ready_in) begin
      vld_p1 <= 1'b0;
    end
  end

`ifdef RENAME_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (bus.valid_in && rd_used_eff && count == '0 && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_fl_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_rename_unit.sv
`timescale 1ns/1ps
module tb_rename_unit;
  import rename_unit_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush_i = 1'b0;
  logic            commit_valid_i = 1'b0;
  logic            commit_rd_used_i = 1'b0;
  areg_t           commit_rd_arch_i = '0;
  preg_t           commit_dest_new_i = '0;
  preg_t           commit_dest_old_i = '0;
  logic [PREG_W:0] free_count_o;
`ifdef RENAME_PERF_CNT_EN
  logic [31:0]     stall_fl_cnt_o;
`endif

  rename_unit_if bus();

  rename_unit dut (
    .clk               (clk),
    .rst               (rst),
    .flush_i           (flush_i),
    .bus               (bus),
    .commit_valid_i    (commit_valid_i),
    .commit_rd_used_i  (commit_rd_used_i),
    .commit_rd_arch_i  (commit_rd_arch_i),
    .commit_dest_new_i (commit_dest_new_i),
    .commit_dest_old_i (commit_dest_old_i),
    .free_count_o      (free_count_o)
`ifdef RENAME_PERF_CNT_EN
    ,
    .stall_fl_cnt_o    (stall_fl_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: free pool as an ordered queue, in-flight dest-writers as
  // a ROB queue, speculative and committed maps as plain arrays.
  typedef struct {
    int arch;
    int new_tag;
    int old_tag;
  } rob_ent_t;

  int          free_q[$];
  rob_ent_t    rob_q[$];
  int          spec_map[NUM_ARCH];
  int          arch_map[NUM_ARCH];
  rename_pkt_t exp_q[$];
  bit          exp_vld_now = 1'b0;
  bit          exp_vld_nxt = 1'b0;
  int          exp_cnt_now = 0;
  bit          model_active = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    free_q.delete();
    rob_q.delete();
    exp_q.delete();
    for (int i = NUM_ARCH; i < NUM_PHYS; i++) free_q.push_back(i);
    for (int i = 0; i < NUM_ARCH; i++) begin
      spec_map[i] = i;
      arch_map[i] = i;
    end
    exp_vld_nxt = 1'b0;
  endfunction

  function automatic decode_pkt_t mk(input int rd, input int rs1, input int rs2, input bit rd_used);
    decode_pkt_t d;
    d          = '0;
    d.rd       = areg_t'(rd);
    d.rs1      = areg_t'(rs1);
    d.rs2      = areg_t'(rs2);
    d.rs1_used = 1'b1;
    d.rs2_used = 1'b1;
    d.rd_used  = rd_used;
    d.fu_type  = FU_ALU;
    d.payload  = $urandom;
    return d;
  endfunction

  task automatic idle_inputs();
    bus.valid_in      = 1'b0;
    bus.pkt_in        = '0;
    bus.ready_in      = 1'b1;
    flush_i           = 1'b0;
    commit_valid_i    = 1'b0;
    commit_rd_used_i  = 1'b0;
    commit_rd_arch_i  = '0;
    commit_dest_new_i = '0;
    commit_dest_old_i = '0;
  endtask

  task automatic do_reset();
    model_active = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    exp_vld_now  = 1'b0;
    exp_cnt_now  = free_q.size();
    model_active = 1'b1;
  endtask

  // One clock of stimulus. cmode: 0 none, 1 commit oldest dest-writer,
  // 2 commit of an instruction without rd.
  task automatic step(input bit v, input decode_pkt_t d, input bit rdy, input int cmode, input bit fl);
    bit          wr, exp_rdy, fire, cwr;
    rename_pkt_t e;
    rob_ent_t    ce;
    @(posedge clk);
    #1;
    exp_vld_now = exp_vld_nxt;
    exp_cnt_now = free_q.size();
    bus.valid_in = v;
    bus.pkt_in   = d;
    bus.ready_in = rdy;
    flush_i      = fl;
    cwr          = 1'b0;
    ce           = '{0, 0, 0};
    if (cmode == 1 && rob_q.size() > 0) begin
      ce                = rob_q[0];
      cwr               = 1'b1;
      commit_valid_i    = 1'b1;
      commit_rd_used_i  = 1'b1;
      commit_rd_arch_i  = areg_t'(ce.arch);
      commit_dest_new_i = preg_t'(ce.new_tag);
      commit_dest_old_i = preg_t'(ce.old_tag);
    end else if (cmode == 2) begin
      commit_valid_i    = 1'b1;
      commit_rd_used_i  = 1'b0;
      commit_rd_arch_i  = areg_t'($urandom);
      commit_dest_new_i = preg_t'($urandom);
      commit_dest_old_i = preg_t'($urandom);
    end else begin
      commit_valid_i    = 1'b0;
      commit_rd_used_i  = 1'b0;
    end
    #1;
    wr      = d.rd_used && (d.rd != 0);
    exp_rdy = (!exp_vld_now || rdy) && (!wr || free_q.size() != 0) && !fl;
    check("ready_out", 128'(bus.ready_out), 128'(exp_rdy));
    fire = v && exp_rdy;
    if (fire) begin
      e            = '0;
      e.dec        = d;
      e.dec.rd_used = wr;
      e.rs1_tag    = preg_t'(spec_map[d.rs1]);
      e.rs2_tag    = preg_t'(spec_map[d.rs2]);
      if (wr) begin
        int nt;
        int ot;
        ot = spec_map[d.rd];
        nt = free_q.pop_front();
        spec_map[d.rd] = nt;
        e.rd_old_tag = preg_t'(ot);
        e.rd_new_tag = preg_t'(nt);
        rob_q.push_back('{int'(d.rd), nt, ot});
      end
      exp_q.push_back(e);
    end
    if (cwr) begin
      arch_map[ce.arch] = ce.new_tag;
      free_q.push_back(ce.old_tag);
      void'(rob_q.pop_front());
    end
    if (fl) begin
      for (int i = 0; i < NUM_ARCH; i++) spec_map[i] = arch_map[i];
      for (int i = rob_q.size() - 1; i >= 0; i--) free_q.push_front(rob_q[i].new_tag);
      rob_q.delete();
      exp_q.delete();
    end
    exp_vld_nxt = fl ? 1'b0 : (fire ? 1'b1 : (rdy ? 1'b0 : exp_vld_now));
  endtask

  task automatic idle_step();
    step(1'b0, '0, 1'b1, 0, 1'b0);
  endtask

  // Monitor: compares registered state and pops the scoreboard on handoff.
  always @(negedge clk) begin
    if (model_active) begin
      check("valid_out", 128'(bus.valid_out), 128'(exp_vld_now));
      check("free_count", 128'(free_count_o), 128'(exp_cnt_now));
      if (bus.valid_out && bus.ready_in && !flush_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL pkt_unexpected: got %0h expected none (t=%0t)", bus.pkt_out, $time);
        end else begin
          rename_pkt_t e;
          e = exp_q.pop_front();
          check("pkt_out", 128'(bus.pkt_out), 128'(e));
        end
      end
    end
  end

  initial begin
    idle_inputs();

    // Reset state
    do_reset();
    check("rst_valid_out", 128'(bus.valid_out), 128'(0));
    check("rst_pkt_out", 128'(bus.pkt_out), 128'(0));
    check("rst_free_count", 128'(free_count_o), 128'(32));
    check("rst_ready_out", 128'(bus.ready_out), 128'(1));

    // add x5, x5, x0
    step(1'b1, mk(5, 5, 0, 1'b1), 1'b1, 0, 1'b0);
    idle_step();
    check("x5_rs1_tag", 128'(bus.pkt_out.rs1_tag), 128'(5));
    check("x5_rs2_tag", 128'(bus.pkt_out.rs2_tag), 128'(0));
    check("x5_rd_old", 128'(bus.pkt_out.rd_old_tag), 128'(5));
    check("x5_rd_new", 128'(bus.pkt_out.rd_new_tag), 128'(32));
    check("x5_free", 128'(free_count_o), 128'(31));

    // Drain the free list with 32 writers
    do_reset();
    step(1'b1, mk(7, 1, 2, 1'b1), 1'b1, 0, 1'b0);
    for (int i = 1; i < 32; i++) step(1'b1, mk((i % 31) + 1, i % 32, 3, 1'b1), 1'b1, 0, 1'b0);
    idle_step();
    check("empty_free", 128'(free_count_o), 128'(0));
    step(1'b1, mk(9, 1, 1, 1'b1), 1'b1, 0, 1'b0);
    check("empty_blocks_writer", 128'(bus.ready_out), 128'(0));
    step(1'b1, mk(9, 1, 1, 1'b0), 1'b1, 0, 1'b0);
    check("empty_rdless_fires", 128'(bus.ready_out), 128'(1));
    step(1'b0, '0, 1'b1, 1, 1'b0);
    idle_step();
    check("recycle_free", 128'(free_count_o), 128'(1));
    step(1'b1, mk(4, 2, 2, 1'b1), 1'b1, 0, 1'b0);
    idle_step();
    check("recycle_tag", 128'(bus.pkt_out.rd_new_tag), 128'(7));

    // Flush restores the committed map and free list
    do_reset();
    step(1'b1, mk(3, 1, 2, 1'b1), 1'b1, 0, 1'b0);
    step(1'b1, mk(3, 3, 2, 1'b1), 1'b1, 0, 1'b0);
    step(1'b0, '0, 1'b1, 1, 1'b0);
    step(1'b0, '0, 1'b1, 0, 1'b1);
    idle_step();
    check("flush_free", 128'(free_count_o), 128'(32));
    check("flush_valid", 128'(bus.valid_out), 128'(0));
    step(1'b1, mk(6, 3, 0, 1'b1), 1'b1, 0, 1'b0);
    idle_step();
    check("flush_map3", 128'(bus.pkt_out.rs1_tag), 128'(32));
    check("flush_retag", 128'(bus.pkt_out.rd_new_tag), 128'(33));

    // Backpressure hold
    do_reset();
    step(1'b1, mk(5, 1, 2, 1'b1), 1'b1, 0, 1'b0);
    step(1'b1, mk(6, 5, 2, 1'b1), 1'b0, 0, 1'b0);
    check("hold_ready", 128'(bus.ready_out), 128'(0));
    step(1'b1, mk(6, 5, 2, 1'b1), 1'b0, 0, 1'b0);
    check("hold_pkt", 128'(bus.pkt_out.rd_new_tag), 128'(32));
    check("hold_nopop", 128'(free_count_o), 128'(31));
    step(1'b1, mk(6, 5, 2, 1'b1), 1'b1, 0, 1'b0);
    idle_step();
    check("release_tag", 128'(bus.pkt_out.rd_new_tag), 128'(33));
    check("release_rs1", 128'(bus.pkt_out.rs1_tag), 128'(32));

    // rd = x0 with rd_used set
    step(1'b1, mk(0, 5, 6, 1'b1), 1'b1, 0, 1'b0);
    idle_step();
    check("x0_rd_used", 128'(bus.pkt_out.dec.rd_used), 128'(0));
    check("x0_rd_new", 128'(bus.pkt_out.rd_new_tag), 128'(0));
    check("x0_nopop", 128'(free_count_o), 128'(30));

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      decode_pkt_t d;
      int          cm;
      d           = mk($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                       ($urandom_range(0, 99) < 85));
      d.rs1_used  = $urandom_range(0, 1);
      d.rs2_used  = $urandom_range(0, 1);
      d.fu_type   = fu_type_e'($urandom_range(0, 3));
      d.is_branch = (d.fu_type == FU_BR);
      cm          = ($urandom_range(0, 2) == 0) ? 1 : (($urandom_range(0, 9) == 0) ? 2 : 0);
      step(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 3) != 0), cm,
           ($urandom_range(0, 39) == 0));
    end
    repeat (3) idle_step();
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
